// File: rtl/gmii_rx_latency.sv
// GMII receive frame checker and latency meter: frame delineation, in-line FCS check,
// DEADBEEF/timestamp extraction and good/error statistics.
// Optional min/max latency tracking is built when GMII_RX_LATENCY_MINMAX_EN is defined.
module gmii_rx_latency #(
  parameter int unsigned MIN_LEN   = 64,
  parameter int unsigned MAGIC_OFS = 42,
  parameter int unsigned STAMP_OFS = 46
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic [31:0] timer,
  input  logic        clear,
  output logic        lat_valid,
  output logic [31:0] latency,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [31:0] lat_min,
  output logic [31:0] lat_max
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] MAGIC_WORD  = 32'hDEADBEEF;
  localparam logic [10:0] IDX_MAX     = 11'h7FF;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state, state_next;
  logic        sfd_hit, eof;
  logic [31:0] t_rx;
  logic [31:0] crc;
  logic [10:0] byte_idx;
  logic [31:0] magic;
  logic [31:0] stamp;
  logic        frame_good;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    sfd_hit    = 1'b0;
    eof        = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv) state_next = (rx_data == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv)                 state_next = IDLE;
        else if (rx_data == 8'hD5) begin
          state_next = DATA;
          sfd_hit    = 1'b1;
        end
        else if (rx_data != 8'h55) state_next = DROP;
      end
      DATA: begin
        if (!rx_dv) begin
          state_next = IDLE;
          eof        = 1'b1;
        end
      end
      DROP: begin
        if (!rx_dv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // byte_idx saturates at 2047, so a saturated count also marks an oversize frame
  assign frame_good = (byte_idx >= 11'(MIN_LEN)) && (byte_idx != IDX_MAX) &&
                      (crc == CRC_RESIDUE);

  always_ff @(posedge clock) begin
    if (reset) begin
      t_rx     <= '0;
      crc      <= '1;
      byte_idx <= '0;
      magic    <= '0;
      stamp    <= '0;
    end
    else if (sfd_hit) begin
      t_rx     <= timer;
      crc      <= '1;
      byte_idx <= '0;
      magic    <= '0;
      stamp    <= '0;
    end
    else if (state == DATA && rx_dv) begin
      crc <= crc_step(crc, rx_data);
      if (byte_idx != IDX_MAX) byte_idx <= byte_idx + 11'd1;
      if (byte_idx >= 11'(MAGIC_OFS) && byte_idx < 11'(MAGIC_OFS + 4))
        magic <= {magic[23:0], rx_data};
      if (byte_idx >= 11'(STAMP_OFS) && byte_idx < 11'(STAMP_OFS + 4))
        stamp <= {stamp[23:0], rx_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_valid <= 1'b0;
      latency   <= '0;
    end
    else begin
      lat_valid <= 1'b0;
      if (eof && frame_good && magic == MAGIC_WORD) begin
        lat_valid <= 1'b1;
        latency   <= t_rx - stamp;
      end
    end
  end

  // clear takes priority over a coinciding end-of-frame for the statistics
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end
    else if (clear) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end
    else if (eof) begin
      if (frame_good) begin
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
      end
      else begin
        if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

`ifdef GMII_RX_LATENCY_MINMAX_EN
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end
    else if (lat_valid) begin
      if (latency < lat_min) lat_min <= latency;
      if (latency > lat_max) lat_max <= latency;
    end
  end
`else
  assign lat_min = '1;
  assign lat_max = '0;
`endif

endmodule
